ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: IFETCH_QUEUE

---
 rtl/ifetch_queue.sv | 115 +++++++++++
 tb/tb_ifetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_queue
//  Purpose  : Instruction prefetch queue. Issues sequential word fetches to a
//             shared RAM port, buffers returned words with their successor
//             PC, and presents the head entry to the fetch/decode register.
//             A redirect flushes the queue and restarts fetch at a new PC.
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_next_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] C_DEPTH     = (CW + 1)'(DEPTH);
  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_ins_mem [DEPTH];
  logic [31:0]   r_npc_mem [DEPTH];

  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // Entries already held plus the one that may still land; a pop in the same
  // cycle deliberately earns no credit so the FIFO can never overflow.
  assign w_used        = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_redirect_pc = redirect_pc & C_WORD_MASK;

  assign mem_req  = reset_n & ~redirect & (w_used < C_DEPTH);
  assign mem_addr = r_fetch_pc;

  assign w_issue  = mem_req & mem_gnt;
  assign w_push   = mem_rvalid & r_inflight & ~redirect;
  assign w_pop    = out_valid & out_ready & ~redirect;

  assign out_valid   = (r_count != '0);
  assign out_ins     = r_ins_mem[r_rd_ptr];
  assign out_next_pc = r_npc_mem[r_rd_ptr];

  // Fetch PC, outstanding-request tracking, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC & C_WORD_MASK;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Queue storage: the successor PC is stored directly so cleared entries
  // read back as zero on both output buses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ins_mem[i] <= '0;
        r_npc_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_ins_mem[r_wr_ptr] <= mem_rdata;
      r_npc_mem[r_wr_ptr] <= r_inflight_pc + 32'd4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_queue
//  Purpose  : Directed self-checking bench for ifetch_queue. The RAM model
//             answers every granted request one cycle later with its address
//             as data. A non-zero RESET_PC is used so the restart address is
//             distinguishable from an address of zero.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

  localparam logic [31:0] C_RESET_PC = 32'h0000_1000;

  logic        clk;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_next_pc;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_next_pc (out_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, returns the address as the data word.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  end
  always @(posedge clk) begin
    mem_rvalid <= mem_req & mem_gnt;
    mem_rdata  <= mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] f_gnt  [7] = '{1, 0, 0, 1, 1, 1, 1};
  logic [31:0] f_addr [7] = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C, 32'h210};
  logic [31:0] f_vld  [7] = '{0, 0, 1, 0, 0, 1, 1};
  logic [31:0] f_ins  [7] = '{0, 0, 32'h200, 0, 0, 32'h204, 32'h208};

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_gnt     = 1'b0;
    out_ready   = 1'b0;
    #3;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ins", out_ins, 32'd0);
    chk("rst_npc", out_next_pc, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);

    // Streaming: one word per cycle, ins = address, next_pc = ins + 4.
    step();
    reset_n   = 1'b1;
    mem_gnt   = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        step();
        #1;
      end
      chk("stream_req", {31'b0, mem_req}, 32'd1);
      chk("stream_addr", mem_addr, C_RESET_PC + 32'(4 * k));
      if (k < 2) begin
        chk("stream_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_ins", out_ins, C_RESET_PC + 32'(4 * (k - 2)));
        chk("stream_npc", out_next_pc, C_RESET_PC + 32'(4 * (k - 2)) + 32'd4);
      end
    end

    // Backpressure: fill the queue, no extra requests, then drain in order.
    step();
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    #1;
    chk("redir_req_off", {31'b0, mem_req}, 32'd0);
    for (int d = 0; d < 7; d++) begin
      step();
      redirect = 1'b0;
      #1;
      if (d < 4) begin
        chk("fill_req", {31'b0, mem_req}, 32'd1);
        chk("fill_addr", mem_addr, 32'(4 * d));
      end else begin
        chk("full_req", {31'b0, mem_req}, 32'd0);
      end
      if (d < 2) begin
        chk("fill_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("fill_valid", {31'b0, out_valid}, 32'd1);
        chk("fill_head", out_ins, 32'd0);
      end
    end
    for (int e = 0; e < 5; e++) begin
      step();
      out_ready = 1'b1;
      #1;
      chk("drain_ins", out_ins, 32'(4 * e));
      if (e == 0) begin
        chk("drain_nocredit", {31'b0, mem_req}, 32'd0);
      end else begin
        chk("drain_addr", mem_addr, 32'(12 + 4 * e));
      end
    end

    // Redirect colliding with a grant offer, a response and a pop.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("coll_req", {31'b0, mem_req}, 32'd0);
    chk("coll_addr", mem_addr, 32'h20);
    chk("coll_ins", out_ins, 32'd20);
    step();
    redirect = 1'b0;
    #1;
    chk("post_redir_valid", {31'b0, out_valid}, 32'd0);
    chk("post_redir_addr", mem_addr, 32'h100);
    step();
    #1;
    chk("post_redir_valid2", {31'b0, out_valid}, 32'd0);
    chk("post_redir_addr2", mem_addr, 32'h104);
    step();
    #1;
    chk("post_redir_valid3", {31'b0, out_valid}, 32'd1);
    chk("post_redir_ins", out_ins, 32'h100);
    chk("post_redir_npc", out_next_pc, 32'h104);

    // Grant stalls: address held, nothing skipped or repeated.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    for (int f = 0; f < 7; f++) begin
      step();
      redirect = 1'b0;
      mem_gnt  = f_gnt[f][0];
      #1;
      chk("stall_addr", mem_addr, f_addr[f]);
      chk("stall_valid", {31'b0, out_valid}, f_vld[f]);
      if (f_vld[f] != 0) begin
        chk("stall_ins", out_ins, f_ins[f]);
      end
    end

    // Held redirect with unaligned target, then address wrap at 2^32.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    #1;
    chk("hold_req1", {31'b0, mem_req}, 32'd0);
    step();
    redirect_pc = 32'hFFFF_FFFB;
    #1;
    chk("hold_req2", {31'b0, mem_req}, 32'd0);
    chk("hold_addr", mem_addr, 32'h500);
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    step();
    #1;
    chk("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_addr2", mem_addr, 32'h0);
    chk("wrap_ins0", out_ins, 32'hFFFF_FFF8);
    chk("wrap_npc0", out_next_pc, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_ins1", out_ins, 32'hFFFF_FFFC);
    chk("wrap_npc1", out_next_pc, 32'h0);
    step();
    #1;
    chk("wrap_ins2", out_ins, 32'h0);
    chk("wrap_npc2", out_next_pc, 32'h4);

    // Reset with three entries queued and a response outstanding.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    #1;
    for (int h = 0; h < 5; h++) begin
      step();
      redirect = 1'b0;
      #1;
      if (h < 4) begin
        chk("pre_rst_addr", mem_addr, 32'(4 * h));
      end else begin
        chk("pre_rst_req", {31'b0, mem_req}, 32'd0);
        chk("pre_rst_ins", out_ins, 32'd0);
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_ins", out_ins, 32'd0);
    chk("async_npc", out_next_pc, 32'd0);
    chk("async_req", {31'b0, mem_req}, 32'd0);
    step();
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("restart_req", {31'b0, mem_req}, 32'd1);
    chk("restart_addr", mem_addr, C_RESET_PC);
    chk("restart_valid", {31'b0, out_valid}, 32'd0);
    step();
    #1;
    chk("restart_valid2", {31'b0, out_valid}, 32'd0);
    chk("restart_addr2", mem_addr, C_RESET_PC + 32'd4);
    step();
    #1;
    chk("restart_valid3", {31'b0, out_valid}, 32'd1);
    chk("restart_ins", out_ins, C_RESET_PC);
    chk("restart_npc", out_next_pc, C_RESET_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
